// File: rtl/rv_hart_sched.sv
// Barrel-thread scheduler: round-robin issue over active harts with a shadow pipeline
// that returns each issued hart id PIPE_DEPTH cycles later, never two in flight per hart.
module rv_hart_sched #(
    parameter int          PIPE_DEPTH = 4,
    parameter logic [7:0]  RESET_MASK = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       start_valid,
    input  logic [2:0] start_id,
    input  logic       stop_valid,
    input  logic [2:0] stop_id,
    output logic [2:0] hart_out,
    output logic       issue_valid,
    output logic [2:0] hart_in,
    output logic       commit_valid,
    output logic [7:0] active_mask,
    output logic       idle
);

    logic [PIPE_DEPTH:0] stg_valid;
    logic [2:0]          stg_id [0:PIPE_DEPTH];
    logic [2:0]          last_ptr;
    logic [7:0]          mask;
    logic [7:0]          inflight;
    logic [7:0]          eligible;
    logic [7:0]          start_onehot;
    logic [7:0]          stop_onehot;
    logic                sel_found;
    logic [2:0]          sel_id;
    logic [2:0]          cand;

    // The last stage is left out: its PC write lands on the same edge as a new issue.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (stg_valid[k]) inflight[stg_id[k]] = 1'b1;
        end
    end

    assign eligible     = mask & ~inflight;
    assign start_onehot = start_valid ? (8'h01 << start_id) : 8'h00;
    assign stop_onehot  = stop_valid  ? (8'h01 << stop_id)  : 8'h00;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = 3'd0;
        cand      = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_ptr + 3'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_id    = cand;
            end
        end
    end

    // The mask tracks start/stop strobes even while the pipeline is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= '0;
            for (int k = 0; k <= PIPE_DEPTH; k++) stg_id[k] <= 3'd0;
            last_ptr  <= 3'd7;
            mask      <= RESET_MASK;
        end else begin
            mask <= (mask | start_onehot) & ~stop_onehot;
            if (en) begin
                stg_valid <= {stg_valid[PIPE_DEPTH-1:0], sel_found};
                for (int k = 1; k <= PIPE_DEPTH; k++) stg_id[k] <= stg_id[k-1];
                stg_id[0] <= sel_id;
                if (sel_found) last_ptr <= sel_id;
            end
        end
    end

    assign hart_out     = stg_id[0];
    assign issue_valid  = stg_valid[0];
    assign hart_in      = stg_id[PIPE_DEPTH];
    assign commit_valid = stg_valid[PIPE_DEPTH];
    assign active_mask  = mask;
    assign idle         = (mask == 8'h00) && !(|stg_valid);

endmodule

// File: tb/tb_rv_hart_sched.sv
// Directed bench for rv_hart_sched (PIPE_DEPTH=4, RESET_MASK=8'h01).
module tb_rv_hart_sched;

    localparam int PD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic       start_valid = 1'b0;
    logic [2:0] start_id = 3'd0;
    logic       stop_valid = 1'b0;
    logic [2:0] stop_id = 3'd0;
    logic [2:0] hart_out;
    logic       issue_valid;
    logic [2:0] hart_in;
    logic       commit_valid;
    logic [7:0] active_mask;
    logic       idle;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    rv_hart_sched #(.PIPE_DEPTH(PD), .RESET_MASK(8'h01)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .start_valid(start_valid), .start_id(start_id),
        .stop_valid(stop_valid), .stop_id(stop_id),
        .hart_out(hart_out), .issue_valid(issue_valid),
        .hart_in(hart_in), .commit_valid(commit_valid),
        .active_mask(active_mask), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] prev;
        logic [2:0] seq3 [0:8];
        logic [2:0] seq5 [0:6];
        logic [2:0] cin5 [0:4];
        logic [2:0] stops [0:5];
        logic [2:0] f_out, f_in;
        logic       f_cv;
        logic       found;
        logic       seen;
        int         since;

        seq3  = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd3, 3'd4};
        seq5  = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7, 3'd0};
        cin5  = '{3'd1, 3'd3, 3'd4, 3'd7, 3'd0};
        stops = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd7};

        // reset values
        tick();
        tick();
        check("rst_issue_valid", issue_valid, 0);
        check("rst_hart_out", hart_out, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_hart_in", hart_in, 0);
        check("rst_mask", active_mask, 8'h01);
        check("rst_idle", idle, 0);
        rst_n = 1'b1;

        // single hart: one issue every PD+1 cycles, commit PD cycles later
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t1_issue_%0d", i), issue_valid, (i % 5) == 0);
            check($sformatf("t1_commit_%0d", i), commit_valid, (i % 5) == 4);
            check($sformatf("t1_hart_out_%0d", i), hart_out, 0);
            check($sformatf("t1_hart_in_%0d", i), hart_in, 0);
        end

        // start harts 1..7 on consecutive cycles, then steady round-robin
        for (int i = 1; i < 8; i++) begin
            start_valid = 1'b1;
            start_id    = 3'(i);
            tick();
        end
        start_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t2_mask", active_mask, 8'hFF);
        exp_q.delete();
        prev = hart_out;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("t2_issue_%0d", i), issue_valid, 1);
            check($sformatf("t2_hart_out_%0d", i), hart_out, 3'(prev + 3'd1));
            if (i >= PD) begin
                check($sformatf("t2_commit_%0d", i), commit_valid, 1);
                check($sformatf("t2_hart_in_%0d", i), hart_in, exp_q.pop_front());
            end
            exp_q.push_back(hart_out);
            prev = hart_out;
        end

        // stop hart 2 while it sits in stage 1
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (hart_out == 3'd2 && issue_valid) found = 1'b1;
        end
        check("t3_found_hart2", found, 1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("t3_issue_%0d", i), issue_valid, 1);
            check($sformatf("t3_hart_out_%0d", i), hart_out, seq3[i-1]);
            if (i == PD) begin
                check("t3_commit_hart2_valid", commit_valid, 1);
                check("t3_commit_hart2_id", hart_in, 2);
            end
            stop_valid = (i == 1);
            stop_id    = 3'd2;
        end
        stop_valid = 1'b0;
        check("t3_mask", active_mask, 8'hFB);

        // start and stop of the same hart in one cycle: stop wins
        start_valid = 1'b1; start_id = 3'd5;
        stop_valid  = 1'b1; stop_id  = 3'd5;
        tick();
        check("t4_active_5", active_mask, 8'hDB);
        tick();
        check("t4_inactive_5", active_mask, 8'hDB);
        start_valid = 1'b0;
        stop_id     = 3'd6;
        tick();
        stop_valid = 1'b0;
        check("t4_stop6", active_mask, 8'h9B);
        for (int i = 0; i < 20; i++) tick();

        // stall 3 cycles with a start of hart 6 during the stall
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (hart_out == 3'd7 && issue_valid) found = 1'b1;
        end
        check("t5_found_hart7", found, 1);
        f_out = hart_out; f_in = hart_in; f_cv = commit_valid;
        check("t5_pre_hart_in", hart_in, 0);
        en = 1'b0;
        start_valid = 1'b1; start_id = 3'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
            start_valid = 1'b0;
            check($sformatf("t5_frz_out_%0d", i), hart_out, f_out);
            check($sformatf("t5_frz_in_%0d", i), hart_in, f_in);
            check($sformatf("t5_frz_cv_%0d", i), commit_valid, f_cv);
            check($sformatf("t5_mask6_%0d", i), active_mask[6], 1);
        end
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("t5_issue_%0d", i), issue_valid, 1);
            check($sformatf("t5_hart_out_%0d", i), hart_out, seq5[i]);
            if (i < 5) begin
                check($sformatf("t5_commit_%0d", i), commit_valid, 1);
                check($sformatf("t5_hart_in_%0d", i), hart_in, cin5[i]);
            end
        end

        // stop every hart; idle rises PD+1 cycles after the last issue
        seen = 1'b0;
        since = 0;
        for (int c = 0; c < 30; c++) begin
            stop_valid = (c < 6);
            stop_id    = (c < 6) ? stops[c] : 3'd0;
            tick();
            if (issue_valid) since = 0;
            else since++;
            if (idle && !seen) begin
                seen = 1'b1;
                check("t6_idle_delay", since, PD + 1);
            end
        end
        stop_valid = 1'b0;
        check("t6_idle_seen", seen, 1);
        check("t6_mask_zero", active_mask, 8'h00);
        check("t6_no_issue", issue_valid, 0);

        // async reset mid-stream
        start_valid = 1'b1; start_id = 3'd5;
        tick();
        start_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (issue_valid) found = 1'b1;
        end
        check("t6_restart_issue", found, 1);
        check("t6_restart_id", hart_out, 5);
        #2 rst_n = 1'b0;
        #1;
        check("t6_arst_issue", issue_valid, 0);
        check("t6_arst_hart_out", hart_out, 0);
        check("t6_arst_commit", commit_valid, 0);
        check("t6_arst_mask", active_mask, 8'h01);
        tick();
        rst_n = 1'b1;
        tick();
        check("t6_post_rst_issue", issue_valid, 1);
        check("t6_post_rst_hart", hart_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
